// File: rtl/qft_bitrev_stream.sv
// Streaming bit-reversal reorder buffer for the serial QFT datapath.
// Fills one 2^NQ-amplitude frame in natural order, then drains it so that output k carries input bitrev(k).
module qft_bitrev_stream #(
  parameter int NQ    = 3,
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_r,
  input  logic signed [WIDTH-1:0] in_i,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_r,
  output logic signed [WIDTH-1:0] out_i,
  output logic [NQ-1:0]           out_idx,
  output logic                    out_last,
  output logic                    frame_err
);

  localparam int L = 1 << NQ;
  localparam logic [NQ-1:0] LAST_IDX = {NQ{1'b1}};

  typedef enum logic {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NQ-1:0]        wr_cnt_q, wr_cnt_d;
  logic [NQ-1:0]        rd_cnt_q, rd_cnt_d;
  logic                 frame_err_q, frame_err_d;
  logic                 wr_en_s;
  logic [2*WIDTH-1:0]   mem_q [L];

  function automatic logic [NQ-1:0] bitrev(input logic [NQ-1:0] v);
    logic [NQ-1:0] r;
    for (int b = 0; b < NQ; b++) begin
      r[b] = v[NQ-1-b];
    end
    return r;
  endfunction

  // State, counters and sticky error register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FILL;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Frame storage; writes land at the bit-reversed slot so drain reads sequentially
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < L; n++) begin
        mem_q[n] <= '0;
      end
    end else if (wr_en_s) begin
      mem_q[bitrev(wr_cnt_q)] <= {in_r, in_i};
    end
  end

  // Next-state, counter update and framing checks
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    frame_err_d = frame_err_q;
    wr_en_s     = 1'b0;
    case (state_q)
      S_FILL: begin
        if (in_valid) begin
          if (wr_cnt_q == LAST_IDX) begin
            wr_en_s  = 1'b1;
            wr_cnt_d = '0;
            state_d  = S_DRAIN;
            if (!in_last) begin
              frame_err_d = 1'b1;
            end else begin
              frame_err_d = frame_err_q;
            end
          end else if (in_last) begin
            // Short frame: drop what was collected and restart the fill
            frame_err_d = 1'b1;
            wr_cnt_d    = '0;
          end else begin
            wr_en_s  = 1'b1;
            wr_cnt_d = wr_cnt_q + NQ'(1);
          end
        end else begin
          wr_cnt_d = wr_cnt_q;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (rd_cnt_q == LAST_IDX) begin
            rd_cnt_d = '0;
            state_d  = S_FILL;
          end else begin
            rd_cnt_d = rd_cnt_q + NQ'(1);
          end
        end else begin
          rd_cnt_d = rd_cnt_q;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // Output decode from registered state only; idle outputs are forced to zero
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_r     = '0;
    out_i     = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    case (state_q)
      S_FILL: begin
        in_ready = 1'b1;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_r     = mem_q[rd_cnt_q][2*WIDTH-1:WIDTH];
        out_i     = mem_q[rd_cnt_q][WIDTH-1:0];
        out_idx   = rd_cnt_q;
        out_last  = (rd_cnt_q == LAST_IDX);
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_qft_bitrev_stream.sv
// Self-checking bench for qft_bitrev_stream: directed table of frames, framing corner cases,
// resets mid-frame and randomized frames against a bit-reversal reference model.
module tb_qft_bitrev_stream;

  localparam int NQ = 3;
  localparam int W  = 16;
  localparam int L  = 8;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_r;
  logic signed [W-1:0] in_i;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_r;
  logic signed [W-1:0] out_i;
  logic [NQ-1:0]       out_idx;
  logic                out_last;
  logic                frame_err;

  int checks = 0;
  int errors = 0;

  qft_bitrev_stream #(.NQ(NQ), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
    .out_idx(out_idx), .out_last(out_last), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [L-1:0][W-1:0] frame_t;

  typedef struct {
    frame_t in_r;
    frame_t in_i;
    frame_t exp_r;
    frame_t exp_i;
    int     rdy_mode;
    bit     gaps;
    bit     pre_early;
    bit     exp_err;
  } vec_t;

  vec_t vecs[3];
  int   perm_seq[8] = '{1, 5, 3, 7, 2, 6, 4, 8};
  int   idx_seq[8]  = '{0, 4, 2, 6, 1, 5, 3, 7};

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: out[k] = in[reverse of k's NQ-bit binary digits]
  function automatic int rev_idx(input int k);
    int r = 0;
    for (int b = 0; b < NQ; b++) begin
      if (((k >> b) % 2) == 1) r = r + (1 << (NQ - 1 - b));
    end
    return r;
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"}, 16'(in_ready), 16'd1);
    chk({tag, "_out_valid"}, 16'(out_valid), 16'd0);
    chk({tag, "_out_r"}, out_r, 16'd0);
    chk({tag, "_out_i"}, out_i, 16'd0);
    chk({tag, "_out_idx"}, 16'(out_idx), 16'd0);
    chk({tag, "_out_last"}, 16'(out_last), 16'd0);
    chk({tag, "_frame_err"}, 16'(frame_err), 16'd0);
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1 reset_checks(tag);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Called at #1 after a posedge; returns at #1 after the accepting edge
  task automatic push_beat(input logic [W-1:0] r, input logic [W-1:0] i, input bit last);
    bit rdy_now;
    int cyc = 0;
    bit done = 1'b0;
    in_valid = 1'b1; in_r = r; in_i = i; in_last = last;
    while (!done && cyc < 50) begin
      rdy_now = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (rdy_now) done = 1'b1;
    end
    if (!done) chk("push_timeout", 16'd0, 16'd1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic push_frame(input frame_t fr, input frame_t fi, input bit omit_last, input bit gaps);
    for (int k = 0; k < L; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      push_beat(fr[k], fi[k], (k == L - 1) && !omit_last);
    end
  endtask

  // rdy_mode: 0 always ready, 1 toggles 1010..., 2 random
  task automatic drain_frame(input frame_t er, input frame_t ei, input int rdy_mode, input bit exp_err);
    int  k = 0;
    int  cyc = 0;
    bit  rdy = 1'b1;
    while (k < L && cyc < 200) begin
      if (out_valid !== 1'b1) begin
        chk("drain_out_valid", 16'(out_valid), 16'd1);
        out_ready = 1'b0;
        return;
      end
      chk("drain_in_ready", 16'(in_ready), 16'd0);
      chk("drain_idx", 16'(out_idx), 16'(k));
      chk("drain_r", out_r, er[k]);
      chk("drain_i", out_i, ei[k]);
      chk("drain_last", 16'(out_last), 16'(k == L - 1));
      chk("drain_err", 16'(frame_err), 16'(exp_err));
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      @(posedge clk); #1;
      cyc++;
      if (rdy) k++;
    end
    out_ready = 1'b0;
    if (k < L) chk("drain_timeout", 16'(k), 16'(L));
    chk("post_in_ready", 16'(in_ready), 16'd1);
    chk("post_out_valid", 16'(out_valid), 16'd0);
    chk("post_out_r", out_r, 16'd0);
    chk("post_out_idx", 16'(out_idx), 16'd0);
  endtask

  task automatic model_expect(input frame_t fr, input frame_t fi, output frame_t er, output frame_t ei);
    for (int k = 0; k < L; k++) begin
      er[k] = fr[rev_idx(k)];
      ei[k] = fi[rev_idx(k)];
    end
  endtask

  task automatic rand_frame(output frame_t fr, output frame_t fi);
    for (int k = 0; k < L; k++) begin
      fr[k] = W'($urandom);
      fi[k] = W'($urandom);
    end
  endtask

  initial begin
    frame_t fr, fi, er, ei;

    // Directed table
    for (int v = 0; v < 3; v++) begin
      vecs[v].in_r = '0; vecs[v].in_i = '0; vecs[v].exp_r = '0; vecs[v].exp_i = '0;
    end
    vecs[0].in_r[1] = 16'sd8;  vecs[0].in_r[4] = -16'sd8;
    vecs[0].in_i[3] = 16'sd8;  vecs[0].in_i[6] = -16'sd8;
    vecs[0].exp_r[1] = -16'sd8; vecs[0].exp_r[4] = 16'sd8;
    vecs[0].exp_i[3] = -16'sd8; vecs[0].exp_i[6] = 16'sd8;
    vecs[0].rdy_mode = 0; vecs[0].gaps = 1'b0; vecs[0].pre_early = 1'b0; vecs[0].exp_err = 1'b0;
    for (int k = 0; k < L; k++) begin
      vecs[1].in_r[k]  = W'(k + 1);
      vecs[1].in_i[k]  = W'(-(k + 1));
      vecs[1].exp_r[k] = W'(perm_seq[k]);
      vecs[1].exp_i[k] = W'(-perm_seq[k]);
      vecs[2].in_r[k]  = W'(k);
      vecs[2].exp_r[k] = W'(idx_seq[k]);
    end
    vecs[1].rdy_mode = 1; vecs[1].gaps = 1'b1; vecs[1].pre_early = 1'b0; vecs[1].exp_err = 1'b0;
    vecs[2].rdy_mode = 0; vecs[2].gaps = 1'b0; vecs[2].pre_early = 1'b1; vecs[2].exp_err = 1'b1;

    rst = 1'b0; in_valid = 1'b0; in_r = '0; in_i = '0; in_last = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1 reset_checks("reset0");
    #9 rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 3; v++) begin
      if (vecs[v].pre_early) begin
        for (int k = 0; k < 4; k++) push_beat(W'(100 + k), W'(7), k == 3);
        repeat (4) begin
          chk("early_err", 16'(frame_err), 16'd1);
          chk("early_no_valid", 16'(out_valid), 16'd0);
          chk("early_in_ready", 16'(in_ready), 16'd1);
          @(posedge clk); #1;
        end
      end
      push_frame(vecs[v].in_r, vecs[v].in_i, 1'b0, vecs[v].gaps);
      drain_frame(vecs[v].exp_r, vecs[v].exp_i, vecs[v].rdy_mode, vecs[v].exp_err);
    end

    // Mid-cycle reset clears the sticky error immediately
    pulse_reset("reset_err");

    // Missing in_last: still drains, error flagged
    rand_frame(fr, fi);
    model_expect(fr, fi, er, ei);
    push_frame(fr, fi, 1'b1, 1'b1);
    drain_frame(er, ei, 2, 1'b1);
    pulse_reset("reset_clr");

    // Reset after three output beats
    rand_frame(fr, fi);
    push_frame(fr, fi, 1'b0, 1'b0);
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("middrain_idx", 16'(out_idx), 16'd3);
    out_ready = 1'b0;
    pulse_reset("reset_drain");

    // Randomized frames against the reference model
    for (int f = 0; f < 6; f++) begin
      rand_frame(fr, fi);
      model_expect(fr, fi, er, ei);
      push_frame(fr, fi, 1'b0, 1'b1);
      drain_frame(er, ei, 2, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qft_bitrev_stream.md
# qft_bitrev_stream

Streaming reorder buffer for the QFT datapath. It accepts one frame of 2^NQ complex fixed-point amplitudes serially, in natural basis order, over a valid/ready handshake. It replays the frame in bit-reversed order: output basis index k carries input amplitude bitrev(k). For NQ=3 this is the sequential counterpart of the combinational qubit-0/qubit-2 SWAP stage, and it sits between a serial QFT butterfly core and the downstream consumer.

## Interface
- NQ, 3, number of qubits; frame length L = 2^NQ amplitudes
- WIDTH, `TOTAL_WIDTH (fixed_point_params.vh), signed fixed-point width of each real/imag component
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_r, in_i  in  WIDTH  signed real/imag of input amplitude
- in_last  in  1  marks final beat (index L-1) of input frame
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts beat
- out_r, out_i  out  WIDTH  signed real/imag of output amplitude
- out_idx  out  NQ  basis index of current output beat
- out_last  out  1  final output beat of frame
- frame_err  out  1  sticky framing-error flag

## Operation
- Storage: L-entry register array of {r,i}, 2*WIDTH bits per entry. Write counter wr_cnt and read counter rd_cnt are NQ bits each.
- FSM has two states.
- FILL:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready, write {in_r,in_i} to mem[bitrev(wr_cnt)], then increment wr_cnt.
  - Accepting beat with wr_cnt=L-1 moves to DRAIN and resets wr_cnt to 0.
- DRAIN:
  - in_ready=0, out_valid=1.
  - out_r/out_i = mem[rd_cnt], out_idx = rd_cnt, out_last = (rd_cnt==L-1).
  - On out_valid&out_ready, increment rd_cnt.
  - Accepting beat with rd_cnt=L-1 moves to FILL and resets rd_cnt to 0.
- Resulting mapping: out[k] = in[bitrev(k)]. For NQ=3: 0←0, 1←4, 2←2, 3←6, 4←1, 5←5, 6←3, 7←7.
- No arithmetic is performed; values pass bit-exact with sign preserved.
- Framing rules:
  - in_last accepted with wr_cnt<L-1: set frame_err, discard partial frame (wr_cnt←0), stay in FILL, emit nothing.
  - Beat wr_cnt=L-1 accepted without in_last: set frame_err, frame still completes and drains normally.
- frame_err clears only on rst.
- When out_valid=0: out_r, out_i, out_idx and out_last are all driven 0.
- Reset (any time, including mid-FILL or mid-DRAIN):
  - Current frame is abandoned, array cleared to 0.
  - State=FILL, wr_cnt=rd_cnt=0.
  - Outputs: in_ready=1, out_valid=0, out_r=out_i=0, out_idx=0, out_last=0, frame_err=0.

## Timing
- in_ready and out_valid decode directly from registered state. No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- out_r, out_i, out_idx and out_last decode from registered state/rd_cnt plus array contents. No combinational path from out_ready to these outputs.
- First out_valid: the cycle after the edge that accepts input beat L-1.
- in_ready rises: the cycle after the edge that accepts output beat L-1.
- Minimum frame period is 2L cycles, with no overlap of fill and drain (16 cycles for NQ=3).
- Holding during stalls:
  - out_valid=1 with out_ready=0: out_r, out_i, out_idx, out_last hold stable.
  - in_valid=0 in FILL: wr_cnt holds, no write.
- Input presented in DRAIN is ignored (in_ready=0); the source must hold it.

## Test plan
- Reset: assert rst mid-cycle, no clock edge.
  - Required: in_ready=1, out_valid=0, out_r=out_i=0, out_idx=0, out_last=0, frame_err=0 immediately.
- SWAP equivalence, NQ=3. Frame in index order, all other entries 0: in[1]=(8,0), in[4]=(-8,0), in[3]=(0,8), in[6]=(0,-8).
  - Required: out_idx1=(-8,0), out_idx4=(8,0), out_idx3=(0,-8), out_idx6=(0,8).
  - out_last only on out_idx=7; frame_err=0.
- Full permutation plus backpressure: frame in[k]=(k+1, -(k+1)); in_valid with random gaps; out_ready toggling 1010….
  - Required output order of in_r: 1,5,3,7,2,6,4,8.
  - Data held stable while out_ready=0.
  - in_ready=0 throughout DRAIN.
- Early in_last: in_last on beat 3.
  - Required: frame_err=1, no out_valid.
  - A following correct frame in[k]=(k,0) drains as in_r sequence 0,4,2,6,1,5,3,7.
- Missing in_last: 8 beats, in_last never asserted.
  - Required: frame_err=1 and full 8-beat drain with correct bit-reversed order.
- Reset mid-DRAIN: assert rst after 3 output beats.
  - Required: out_valid=0 at once, in_ready=1.
  - The next frame outputs starting at out_idx=0 with no stale data.
